// File: rtl/excp_flush_ctrl_pkg.sv
// Shared types and constants for the exception / ertn / refetch flush controller.
package excp_flush_ctrl_pkg;

    // Controller sequencing states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    // Codes driven on flush_kind.
    typedef enum logic [1:0] {
        KIND_NONE    = 2'd0,
        KIND_EXCP    = 2'd1,
        KIND_ERTN    = 2'd2,
        KIND_REFETCH = 2'd3
    } kind_t;

    // Number of cycles spent in QUIET after the flush pulse.
    localparam logic [1:0] QUIET_LEN = 2'd2;

    // Resolve simultaneous request bits: exception beats ertn beats refetch.
    function automatic kind_t pick_kind(input logic excp, input logic ertn, input logic refetch);
        if (excp)         return KIND_EXCP;
        else if (ertn)    return KIND_ERTN;
        else if (refetch) return KIND_REFETCH;
        else              return KIND_NONE;
    endfunction

    // Redirect PC for a resolved kind; refetch wraps modulo 2^32.
    function automatic logic [31:0] pick_target(input kind_t       kind,
                                                input logic        tlbrefill,
                                                input logic [31:0] pc,
                                                input logic [31:0] eentry,
                                                input logic [31:0] tlbrentry,
                                                input logic [31:0] era);
        case (kind)
            KIND_EXCP:    return tlbrefill ? tlbrentry : eentry;
            KIND_ERTN:    return era;
            KIND_REFETCH: return pc + 32'd4;
            default:      return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/excp_flush_ctrl.sv
// Sequences a pipeline flush for exceptions, ertn and TLB-op refetches:
// waits for outstanding cache traffic, emits a one-cycle flush with the
// redirect target, then holds the pipeline quiet for a fixed window.
module excp_flush_ctrl
    import excp_flush_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_excp,
    input  logic        req_tlbrefill,
    input  logic        req_ertn,
    input  logic        req_refetch,
    input  logic [31:0] req_pc,
    input  logic [31:0] eentry,
    input  logic [31:0] tlbrentry,
    input  logic [31:0] era,
    input  logic        icache_busy,
    input  logic        dcache_busy,
    output logic        req_ready,
    output logic        stall,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic [1:0]  flush_kind,
    output logic        excp_commit,
    output logic        ertn_commit
);

    state_t      state;
    logic [1:0]  quiet_cnt;
    kind_t       cap_kind;
    logic [31:0] cap_target;   // tlbrefill is folded in here at acceptance

    logic        any_req;
    logic        busy;
    logic        go_flush;
    kind_t       acc_kind;
    logic [31:0] acc_target;
    kind_t       src_kind;
    logic [31:0] src_target;

    // Decode the request and decide whether the next edge enters FLUSH.
    // NOTE: every signal assigned here is written on every path, so no latch is inferred.
    always_comb begin
        any_req    = req_valid & (req_excp | req_ertn | req_refetch);
        busy       = icache_busy | dcache_busy;
        acc_kind   = pick_kind(req_excp, req_ertn, req_refetch);
        acc_target = pick_target(acc_kind, req_tlbrefill, req_pc, eentry, tlbrentry, era);
        go_flush   = ((state == ST_IDLE) & any_req & ~busy) | ((state == ST_DRAIN) & ~busy);
        // A direct IDLE->FLUSH uses the live decode; DRAIN uses what was captured.
        src_kind   = (state == ST_IDLE) ? acc_kind   : cap_kind;
        src_target = (state == ST_IDLE) ? acc_target : cap_target;
    end

    assign req_ready = (state == ST_IDLE);

    // Stall is low in FLUSH so the flush itself can propagate; forced low in reset.
    assign stall = ~reset & ((state == ST_DRAIN) | (state == ST_QUIET) |
                             ((state == ST_IDLE) & any_req & busy));

    // Sequencer FSM with capture registers and registered flush/commit outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            quiet_cnt    <= 2'd0;
            cap_kind     <= KIND_NONE;
            cap_target   <= 32'd0;
            flush        <= 1'b0;
            flush_target <= 32'd0;
            flush_kind   <= KIND_NONE;
            excp_commit  <= 1'b0;
            ertn_commit  <= 1'b0;
        end else begin
            flush        <= go_flush;
            flush_target <= go_flush ? src_target : 32'd0;
            flush_kind   <= go_flush ? src_kind   : KIND_NONE;
            excp_commit  <= go_flush & (src_kind == KIND_EXCP);
            ertn_commit  <= go_flush & (src_kind == KIND_ERTN);

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        cap_kind   <= acc_kind;
                        cap_target <= acc_target;
                        state      <= busy ? ST_DRAIN : ST_FLUSH;
                    end
                end
                ST_DRAIN: begin
                    if (!busy) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    state     <= ST_QUIET;
                    quiet_cnt <= QUIET_LEN - 2'd1;
                end
                ST_QUIET: begin
                    if (quiet_cnt == 2'd0) state     <= ST_IDLE;
                    else                   quiet_cnt <= quiet_cnt - 2'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Directed self-checking bench for excp_flush_ctrl.
module tb_excp_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_excp = 1'b0, req_tlbrefill = 1'b0;
    logic        req_ertn = 1'b0, req_refetch = 1'b0;
    logic [31:0] req_pc = 32'd0, eentry = 32'd0, tlbrentry = 32'd0, era = 32'd0;
    logic        icache_busy = 1'b0, dcache_busy = 1'b0;
    logic        req_ready, stall, flush, excp_commit, ertn_commit;
    logic [31:0] flush_target;
    logic [1:0]  flush_kind;

    int n_checks = 0;
    int n_pass   = 0;

    excp_flush_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_excp(req_excp), .req_tlbrefill(req_tlbrefill),
        .req_ertn(req_ertn), .req_refetch(req_refetch), .req_pc(req_pc),
        .eentry(eentry), .tlbrentry(tlbrentry), .era(era),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy),
        .req_ready(req_ready), .stall(stall), .flush(flush),
        .flush_target(flush_target), .flush_kind(flush_kind),
        .excp_commit(excp_commit), .ertn_commit(ertn_commit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic clear_req();
        req_valid = 1'b0; req_excp = 1'b0; req_tlbrefill = 1'b0;
        req_ertn = 1'b0; req_refetch = 1'b0;
    endtask

    // Move to the middle (low phase) of the next clock cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // One request with both caches idle: accept at T, flush at T+1, IDLE at T+4.
    task automatic run_simple(input string tag, input logic excp, input logic tlb,
                              input logic ertn, input logic refetch, input logic [31:0] pc,
                              input logic [31:0] ee, input logic [31:0] tr, input logic [31:0] ea,
                              input logic [31:0] exp_target, input logic [1:0] exp_kind);
        next_cycle();
        req_valid = 1'b1; req_excp = excp; req_tlbrefill = tlb;
        req_ertn = ertn; req_refetch = refetch; req_pc = pc;
        eentry = ee; tlbrentry = tr; era = ea;
        #1;
        check({tag, "_T_stall"}, stall, 0);
        check({tag, "_T_ready"}, req_ready, 1);
        next_cycle();
        clear_req();
        eentry = ~ee; tlbrentry = ~tr; era = ~ea; req_pc = ~pc;
        #1;
        check({tag, "_flush"},  flush, 1);
        check({tag, "_target"}, flush_target, exp_target);
        check({tag, "_kind"},   flush_kind, exp_kind);
        check({tag, "_excp_commit"}, excp_commit, (exp_kind == 2'd1));
        check({tag, "_ertn_commit"}, ertn_commit, (exp_kind == 2'd2));
        check({tag, "_flush_stall"}, stall, 0);
        check({tag, "_flush_ready"}, req_ready, 0);
        next_cycle(); #1;
        check({tag, "_q1_flush"}, flush, 0);
        check({tag, "_q1_stall"}, stall, 1);
        next_cycle(); #1;
        check({tag, "_q2_stall"}, stall, 1);
        check({tag, "_q2_ready"}, req_ready, 0);
        next_cycle(); #1;
        check({tag, "_idle_ready"}, req_ready, 1);
        check({tag, "_idle_stall"}, stall, 0);
    endtask

    initial begin
        // Reset values.
        next_cycle(); #1;
        check("rst_flush",  flush, 0);
        check("rst_target", flush_target, 0);
        check("rst_kind",   flush_kind, 0);
        check("rst_excp",   excp_commit, 0);
        check("rst_ertn",   ertn_commit, 0);
        check("rst_stall",  stall, 0);
        check("rst_ready",  req_ready, 1);
        reset = 1'b0;

        // Plain exception, caches idle.
        run_simple("excp", 1, 0, 0, 0, 32'h1C000040,
                   32'h1C008000, 32'h1C00F000, 32'h1C000100, 32'h1C008000, 2'd1);
        // ertn and refetch together: ertn wins.
        run_simple("ertn", 0, 0, 1, 1, 32'h1C000200,
                   32'h1C008000, 32'h1C00F000, 32'h1C000100, 32'h1C000100, 2'd2);
        // Refetch wrap-around and an ordinary refetch.
        run_simple("rf_wrap", 0, 0, 0, 1, 32'hFFFFFFFC,
                   32'h1C008000, 32'h1C00F000, 32'h1C000100, 32'h00000000, 2'd3);
        run_simple("rf_pc4", 0, 0, 0, 1, 32'h1C000200,
                   32'h1C008000, 32'h1C00F000, 32'h1C000100, 32'h1C000204, 2'd3);

        // TLB refill (with ertn also set: exception wins), icache busy for T..T+2.
        next_cycle();
        req_valid = 1; req_excp = 1; req_tlbrefill = 1; req_ertn = 1;
        eentry = 32'h1C008000; tlbrentry = 32'h1C00F000; era = 32'h11111111;
        icache_busy = 1;
        #1;
        check("tlb_T_stall", stall, 1);
        check("tlb_T_ready", req_ready, 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            icache_busy = (i < 3);
            tlbrentry = 32'hDEAD0000 + i;
            #1;
            check($sformatf("tlb_T%0d_stall", i), stall, 1);
            check($sformatf("tlb_T%0d_flush", i), flush, 0);
            check($sformatf("tlb_T%0d_ready", i), req_ready, 0);
        end
        next_cycle();
        clear_req();
        dcache_busy = 1;   // busy rising during FLUSH must not matter
        #1;
        check("tlb_flush",  flush, 1);
        check("tlb_target", flush_target, 32'h1C00F000);
        check("tlb_kind",   flush_kind, 1);
        check("tlb_excp",   excp_commit, 1);
        check("tlb_ertn",   ertn_commit, 0);
        check("tlb_stall",  stall, 0);
        next_cycle(); #1;
        check("tlb_q1_stall", stall, 1);
        next_cycle(); dcache_busy = 0; #1;
        check("tlb_q2_stall", stall, 1);
        next_cycle(); #1;
        check("tlb_idle_ready", req_ready, 1);
        check("tlb_idle_flush", flush, 0);

        // Valid with no kind bits: nothing happens even with caches busy.
        next_cycle();
        req_valid = 1; icache_busy = 1; dcache_busy = 1;
        #1;
        check("none_stall", stall, 0);
        check("none_ready", req_ready, 1);
        next_cycle(); #1;
        check("none_n_ready", req_ready, 1);
        check("none_n_flush", flush, 0);
        check("none_n_kind",  flush_kind, 0);
        clear_req(); icache_busy = 0; dcache_busy = 0;

        // Reset while draining: sequence aborted, no flush.
        next_cycle();
        req_valid = 1; req_excp = 1; eentry = 32'h1C008000; dcache_busy = 1;
        #1;
        check("rd_T_stall", stall, 1);
        next_cycle(); #1;
        check("rd_drain_ready", req_ready, 0);
        check("rd_drain_stall", stall, 1);
        reset = 1; dcache_busy = 0; clear_req();
        #1;
        check("rd_rst_stall",  stall, 0);
        check("rd_rst_ready",  req_ready, 1);
        check("rd_rst_flush",  flush, 0);
        check("rd_rst_target", flush_target, 0);
        next_cycle(); #1;
        check("rd_rst2_flush", flush, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            check($sformatf("rd_after%0d_flush", i), flush, 0);
            check($sformatf("rd_after%0d_ready", i), req_ready, 1);
            check($sformatf("rd_after%0d_excp", i), excp_commit, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
